print_channel_arbiter: RTL and testbench

Shares the single character output channel (UART transmitter or Consul printer path) between several byte producers. The producers are the DekatronPC `tx` stream, the keyboard echo, and the debug/status reporters. The block runs a round-robin grant with a holding register. It sequences each character through the sink's slow ready/complete handshake, so individual producers no longer hand-craft edge detection on the sink's ready. It sits in the 1 MHz `Clock_1MHz` domain between the producers and the `uart_tx`/consul `print_data_*` ports.

---
 rtl/dpc_io_pkg.sv | 19 +
 rtl/rr_priority_picker.sv | 30 +++
 rtl/print_channel_arbiter.sv | 115 +++++++++++
 tb/tb_print_channel_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dpc_io_pkg.sv
// Shared DekatronPC I/O definitions: print arbiter states, producer indices
// and the index-width helper used by the arbiter and its picker.
package dpc_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } prnarb_state_t;

  localparam int unsigned PRN_REQ_DPC   = 0;
  localparam int unsigned PRN_REQ_ECHO  = 1;
  localparam int unsigned PRN_REQ_DEBUG = 2;

  function automatic int unsigned prn_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first valid requester after 'last',
// searching last+1, last+2, ... with wrap-around.
module rr_priority_picker
  import dpc_io_pkg::*;
#(
  parameter  int unsigned REQUESTERS = 4,
  localparam int unsigned IW         = prn_idx_w(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0] vld,
  input  logic [IW-1:0]         last,
  output logic [IW-1:0]         winner,
  output logic                  any
);

  int unsigned idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int unsigned i = 1; i <= REQUESTERS; i++) begin
      idx = (32'(last) + i) % REQUESTERS;
      if (!any && vld[idx]) begin
        any    = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/print_channel_arbiter.sv
// Round-robin arbiter sharing one character sink between several producers.
// Optional completion watchdog enabled by defining PRINT_ARB_TIMEOUT_EN.
module print_channel_arbiter
  import dpc_io_pkg::*;
#(
  parameter  int unsigned REQUESTERS     = 4,
  parameter  int unsigned DATA_WIDTH     = 8,
  parameter  int unsigned TIMEOUT_CYCLES = 200000,
  localparam int unsigned IW             = prn_idx_w(REQUESTERS)
) (
  input  logic                             Clk,
  input  logic                             Rst_n,
  input  logic [REQUESTERS*DATA_WIDTH-1:0] req_data_i,
  input  logic [REQUESTERS-1:0]            req_vld_i,
  output logic [REQUESTERS-1:0]            req_rdy_o,
  output logic [DATA_WIDTH-1:0]            sink_data_o,
  output logic                             sink_vld_o,
  input  logic                             sink_rdy_i,
  output logic [IW-1:0]                    grant_o,
  output logic                             busy_o,
  output logic                             timeout_o
);

  prnarb_state_t           state_q, state_d;
  logic [IW-1:0]           last_q, winner;
  logic                    any;
  logic [DATA_WIDTH-1:0]   hold_q, win_data;
  logic [REQUESTERS-1:0]   rdy_d;
  logic                    seen_low_q;
  logic                    grant_en;
  logic                    tmo_hit;

  rr_priority_picker #(.REQUESTERS(REQUESTERS)) u_pick (
    .vld    (req_vld_i),
    .last   (last_q),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    win_data = '0;
    rdy_d    = '0;
    for (int unsigned j = 0; j < REQUESTERS; j++)
      if (winner == IW'(j)) win_data = req_data_i[j*DATA_WIDTH +: DATA_WIDTH];
    case (state_q)
      IDLE:      if (any) begin
                   grant_en = 1'b1;
                   state_d  = ISSUE;
                 end
      ISSUE:     if (sink_rdy_i) state_d = WAIT_DONE;
      WAIT_DONE: if (sink_rdy_i && seen_low_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (tmo_hit) state_d = IDLE;
    for (int unsigned j = 0; j < REQUESTERS; j++)
      rdy_d[j] = grant_en && (winner == IW'(j));
  end

  // seen_low is cleared throughout ISSUE so it always starts clean in WAIT_DONE
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      last_q     <= IW'(REQUESTERS - 1);
      hold_q     <= '0;
      req_rdy_o  <= '0;
      seen_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_rdy_o <= rdy_d;
      if (grant_en) begin
        hold_q <= win_data;
        last_q <= winner;
      end
      if (state_q == ISSUE)
        seen_low_q <= 1'b0;
      else if (state_q == WAIT_DONE && !sink_rdy_i)
        seen_low_q <= 1'b1;
    end
  end

  assign sink_vld_o  = (state_q == ISSUE);
  assign sink_data_o = hold_q;
  assign grant_o     = last_q;
  assign busy_o      = (state_q != IDLE);

`ifdef PRINT_ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        timeout_q;

  assign tmo_hit = (state_q != IDLE) && (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo_hit;
      if (state_d != state_q)
        tmo_cnt_q <= '0;
      else if (state_q != IDLE)
        tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic [31:0] unused_tmo_limit;
  assign unused_tmo_limit = 32'(TIMEOUT_CYCLES);
  assign tmo_hit          = 1'b0;
  assign timeout_o        = 1'b0;
`endif

endmodule

// File: tb/tb_print_channel_arbiter.sv
// Self-checking bench for print_channel_arbiter: table-driven per-cycle
// vectors plus hand-written multi-cycle sequences.
module tb_print_channel_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [31:0] req_data;
  logic [3:0]  req_vld;
  logic [3:0]  req_rdy;
  logic [7:0]  sink_data;
  logic        sink_vld;
  logic        sink_rdy;
  logic [1:0]  grant;
  logic        busy;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

`ifdef PRINT_ARB_TIMEOUT_EN
  localparam int STALL = 10;
`else
  localparam int STALL = 50;
`endif

  print_channel_arbiter #(
    .REQUESTERS     (4),
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .req_data_i  (req_data),
    .req_vld_i   (req_vld),
    .req_rdy_o   (req_rdy),
    .sink_data_o (sink_data),
    .sink_vld_o  (sink_vld),
    .sink_rdy_i  (sink_rdy),
    .grant_o     (grant),
    .busy_o      (busy),
    .timeout_o   (timeout)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] vld;
    logic       rdy;
    logic [3:0] e_rdy;
    logic       e_vld;
    logic [7:0] e_data;
    logic [1:0] e_grant;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic add_row(input logic [3:0] v, input logic r, input logic [3:0] er,
                         input logic ev, input logic [7:0] ed, input logic [1:0] eg,
                         input logic eb);
    vec_t x;
    x.vld = v; x.rdy = r; x.e_rdy = er; x.e_vld = ev;
    x.e_data = ed; x.e_grant = eg; x.e_busy = eb;
    vecs.push_back(x);
  endtask

  // One character with a sink that dips low for one cycle after accept.
  task automatic add_char(input logic [3:0] v, input int g);
    logic [7:0] d;
    logic [3:0] oh;
    d  = 8'hA0 + 8'(g);
    oh = 4'b0001 << g;
    add_row(v, 1'b1, oh,   1'b1, d, 2'(g), 1'b1);
    add_row(v, 1'b1, 4'b0, 1'b0, d, 2'(g), 1'b1);
    add_row(v, 1'b0, 4'b0, 1'b0, d, 2'(g), 1'b1);
    add_row(v, 1'b1, 4'b0, 1'b0, d, 2'(g), 1'b0);
  endtask

  task automatic chk_all(input string nm, input logic [3:0] er, input logic ev,
                         input logic [7:0] ed, input logic [1:0] eg, input logic eb);
    chk({nm, ".rdy"},   32'(req_rdy),   32'(er));
    chk({nm, ".vld"},   32'(sink_vld),  32'(ev));
    chk({nm, ".data"},  32'(sink_data), 32'(ed));
    chk({nm, ".grant"}, 32'(grant),     32'(eg));
    chk({nm, ".busy"},  32'(busy),      32'(eb));
    chk({nm, ".tmo"},   32'(timeout),   32'd0);
  endtask

  initial begin
    int ord[5];
    int stable_bad;
    ord = '{0, 1, 2, 3, 0};

    for (int c = 0; c < 5; c++) add_char(4'b1111, ord[c]);
    add_row(4'b0000, 1'b1, 4'b0, 1'b0, 8'hA0, 2'd0, 1'b0);
    add_char(4'b1010, 1);
    add_char(4'b1001, 3);
    add_char(4'b0001, 0);

    Rst_n    = 1'b0;
    req_vld  = '0;
    req_data = 32'hA3A2_A1A0;
    sink_rdy = 1'b1;
    #12;
    chk_all("reset", 4'b0, 1'b0, 8'h00, 2'd3, 1'b0);
    step();
    Rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      req_vld  = vecs[i].vld;
      sink_rdy = vecs[i].rdy;
      step();
      chk_all($sformatf("row%0d", i), vecs[i].e_rdy, vecs[i].e_vld,
              vecs[i].e_data, vecs[i].e_grant, vecs[i].e_busy);
    end

    // Single request from producer 2, sink busy for 10 cycles after accept.
    req_data[16 +: 8] = 8'h41;
    req_vld = 4'b0100; sink_rdy = 1'b1;
    step();
    chk_all("single.grant", 4'b0100, 1'b1, 8'h41, 2'd2, 1'b1);
    req_vld = '0;
    step();
    chk_all("single.xfer", 4'b0, 1'b0, 8'h41, 2'd2, 1'b1);
    sink_rdy = 1'b0;
    repeat (10) step();
    chk("single.busy_low", 32'(busy), 32'd1);
    sink_rdy = 1'b1;
    step();
    chk("single.release", 32'(busy), 32'd0);

    // Stalled sink: not ready on entry to ISSUE.
    req_data[0 +: 8] = 8'h5A;
    req_vld = 4'b0001; sink_rdy = 1'b0;
    step();
    chk_all("stall.grant", 4'b0001, 1'b1, 8'h5A, 2'd0, 1'b1);
    req_vld = '0;
    stable_bad = 0;
    for (int i = 0; i < STALL; i++) begin
      step();
      if (sink_vld !== 1'b1 || sink_data !== 8'h5A || req_rdy !== 4'b0) stable_bad++;
    end
    chk("stall.hold_cycles_bad", 32'(stable_bad), 32'd0);
    sink_rdy = 1'b1;
    step();
    chk_all("stall.xfer", 4'b0, 1'b0, 8'h5A, 2'd0, 1'b1);
    sink_rdy = 1'b0; step();
    sink_rdy = 1'b1; step();
    chk("stall.release", 32'(busy), 32'd0);

    // Early drop: producer 1 withdraws and changes data after its accept.
    req_data[8 +: 8] = 8'h33;
    req_vld = 4'b0010; sink_rdy = 1'b0;
    step();
    chk_all("drop.grant", 4'b0010, 1'b1, 8'h33, 2'd1, 1'b1);
    req_vld = '0;
    req_data[8 +: 8] = 8'hFF;
    step();
    chk_all("drop.hold", 4'b0, 1'b1, 8'h33, 2'd1, 1'b1);
    sink_rdy = 1'b1;
    step();
    chk_all("drop.xfer", 4'b0, 1'b0, 8'h33, 2'd1, 1'b1);
    sink_rdy = 1'b0; step();
    sink_rdy = 1'b1; step();
    chk("drop.release", 32'(busy), 32'd0);

    // Reset in WAIT_DONE, then the round-robin pointer starts over.
    req_vld = 4'b0100; sink_rdy = 1'b1;
    step();
    chk("rst.pre_grant", 32'(grant), 32'd2);
    req_vld = '0;
    step();
    sink_rdy = 1'b0;
    step();
    chk("rst.in_wait", 32'(busy), 32'd1);
    Rst_n = 1'b0;
    #1;
    chk_all("rst.async", 4'b0, 1'b0, 8'h00, 2'd3, 1'b0);
    step();
    chk_all("rst.held", 4'b0, 1'b0, 8'h00, 2'd3, 1'b0);
    Rst_n = 1'b1; sink_rdy = 1'b1;
    req_data[24 +: 8] = 8'hC3;
    req_data[0 +: 8]  = 8'hC0;
    req_vld = 4'b1001;
    step();
    chk_all("rst.ptr0", 4'b0001, 1'b1, 8'hC0, 2'd0, 1'b1);
    step();
    sink_rdy = 1'b0; step();
    sink_rdy = 1'b1; step();
    step();
    chk_all("rst.grant3", 4'b1000, 1'b1, 8'hC3, 2'd3, 1'b1);
    req_vld = '0;
    step();
    sink_rdy = 1'b0; step();
    sink_rdy = 1'b1; step();
    chk("rst.release", 32'(busy), 32'd0);

`ifdef PRINT_ARB_TIMEOUT_EN
    // Watchdog: sink accepts then never returns ready.
    req_vld = 4'b0001; sink_rdy = 1'b1;
    step();
    req_vld = '0;
    step();
    chk("tmo.in_wait", 32'(busy), 32'd1);
    sink_rdy = 1'b0;
    stable_bad = 0;
    for (int i = 1; i < 16; i++) begin
      step();
      if (timeout !== 1'b0 || busy !== 1'b1) stable_bad++;
    end
    chk("tmo.early_bad", 32'(stable_bad), 32'd0);
    step();
    chk("tmo.pulse", 32'(timeout), 32'd1);
    chk("tmo.idle", 32'(busy), 32'd0);
    req_vld = 4'b0010;
    step();
    chk("tmo.pulse_end", 32'(timeout), 32'd0);
    chk("tmo.next_grant", 32'(req_rdy), 32'b0010);
    req_vld = '0;
`else
    chk("tmo.tied", 32'(timeout), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
